// File: rtl/apb_master.sv
// APB master: accepts single read/write commands and runs them as APB SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] PRDATA
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_done;
    logic                w_abort;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    assign cmd_ready = (r_state == ST_IDLE) || ((r_state == ST_ACCESS) && PREADY);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_done    = (r_state == ST_ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    logic [7:0] r_cnt;

    // Counter holds k-1 during the k-th ACCESS cycle, so the abort lands on ACCESS cycle TIMEOUT_CYCLES.
    assign w_abort = (r_state == ST_ACCESS) && !PREADY && (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !PREADY) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_SETUP;
            end
            ST_SETUP: begin
                w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    w_next = w_accept ? ST_SETUP : ST_IDLE;
                end else if (w_abort) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_pwrite <= cmd_write;
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_wdata;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done || w_abort;
            if (w_done) begin
                r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
                r_rsp_err   <= PSLVERR;
            end else if (w_abort) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign PSELx     = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign PENABLE   = (r_state == ST_ACCESS);
    assign busy      = PSELx;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level model checked every cycle, directed scenarios plus random traffic.
module tb_apb_master;

    localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b0;
    logic       cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0, cmd_wdata = '0;
    logic       cmd_ready;
    logic       rsp_valid, rsp_err, busy;
    logic [7:0] rsp_rdata;
    logic       PSELx, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA;
    logic       PREADY = 1'b0, PSLVERR = 1'b0;
    logic [7:0] PRDATA = '0;

    int total = 0;
    int bad = 0;

    // Model: whether a transfer is on the bus, and which bus cycle of it we are in (0 = setup, k = k-th access).
    bit         m_busy;
    int         m_cyc;
    logic       m_write;
    logic [7:0] m_addr, m_wdata;
    logic       m_rv, m_re;
    logic [7:0] m_rd;

    apb_master #(
        .ADDR_W(8),
        .DATA_W(8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_cyc = 0;
        m_write = 1'b0; m_addr = '0; m_wdata = '0;
        m_rv = 1'b0; m_re = 1'b0; m_rd = '0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic rdy, input logic se, input logic [7:0] rd);
        bit e_ready, done, abort, acc;
        cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        PREADY = rdy; PSLVERR = se; PRDATA = rd;
        #1;
        e_ready = !m_busy || (m_cyc >= 1 && rdy);
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, e_ready});
        chk("busy",      {31'd0, busy},      {31'd0, m_busy});
        chk("PSELx",     {31'd0, PSELx},     {31'd0, m_busy});
        chk("PENABLE",   {31'd0, PENABLE},   {31'd0, (m_busy && m_cyc >= 1)});
        chk("PWRITE",    {31'd0, PWRITE},    {31'd0, m_write});
        chk("PADDR",     {24'd0, PADDR},     {24'd0, m_addr});
        chk("PWDATA",    {24'd0, PWDATA},    {24'd0, m_wdata});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
        chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, m_rd});
        chk("rsp_err",   {31'd0, rsp_err},   {31'd0, m_re});
        @(posedge PCLK);
        done  = m_busy && m_cyc >= 1 && rdy;
        abort = TO_EN && m_busy && m_cyc == TO && !rdy;
        acc   = v && e_ready;
        m_rv  = done || abort;
        if (done) begin
            m_rd = m_write ? 8'h00 : rd;
            m_re = se;
        end else if (abort) begin
            m_rd = 8'h00;
            m_re = 1'b1;
        end
        if (acc) begin
            m_write = w; m_addr = a; m_wdata = d;
            m_busy = 1'b1; m_cyc = 0;
        end else if (done || abort) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_cyc++;
        end
        @(negedge PCLK);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 8'h00, 8'h00, rdy, 1'b0, 8'h00);
    endtask

    initial begin
        model_reset();
        PRESET = 1'b1;
        #1;
        chk("rst_psel_async", {31'd0, PSELx}, 32'd0);
        @(negedge PCLK);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_paddr", {24'd0, PADDR}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        PRESET = 1'b0;

        // Zero-wait write
        step(1'b1, 1'b1, 8'h01, 8'h3C, 1'b1, 1'b0, 8'h00);
        chk("w0_setup_sel", {31'd0, PSELx}, 32'd1);
        chk("w0_setup_en", {31'd0, PENABLE}, 32'd0);
        chk("w0_paddr", {24'd0, PADDR}, 32'h01);
        chk("w0_pwdata", {24'd0, PWDATA}, 32'h3C);
        chk("w0_pwrite", {31'd0, PWRITE}, 32'd1);
        idle(1'b1);
        chk("w0_access_en", {31'd0, PENABLE}, 32'd1);
        idle(1'b1);
        chk("w0_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("w0_rsp_rdata", {24'd0, rsp_rdata}, 32'h00);
        chk("w0_rsp_err", {31'd0, rsp_err}, 32'd0);
        idle(1'b0);

        // Read with two wait states
        step(1'b1, 1'b0, 8'h03, 8'hFF, 1'b0, 1'b0, 8'h00);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("r2_still_access", {31'd0, PENABLE}, 32'd1);
        chk("r2_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5);
        chk("r2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("r2_rsp_rdata", {24'd0, rsp_rdata}, 32'hA5);
        idle(1'b0);
        chk("r2_rdata_hold", {24'd0, rsp_rdata}, 32'hA5);

        // Back-to-back writes, cmd_valid held
        step(1'b1, 1'b1, 8'h04, 8'h11, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h06, 8'h22, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h06, 8'h22, 1'b1, 1'b0, 8'h00);
        chk("b2b_rsp1", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_sel_hi", {31'd0, PSELx}, 32'd1);
        chk("b2b_en_gap", {31'd0, PENABLE}, 32'd0);
        chk("b2b_paddr2", {24'd0, PADDR}, 32'h06);
        idle(1'b1);
        chk("b2b_en_back", {31'd0, PENABLE}, 32'd1);
        idle(1'b1);
        chk("b2b_rsp2", {31'd0, rsp_valid}, 32'd1);

        // Slave error, then a clean transfer
        step(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00);
        idle(1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h5A);
        chk("err_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("err_rsp_rdata", {24'd0, rsp_rdata}, 32'h5A);
        step(1'b1, 1'b1, 8'h08, 8'h77, 1'b0, 1'b0, 8'h00);
        idle(1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("err_clear", {31'd0, rsp_err}, 32'd0);
        chk("err_clear_valid", {31'd0, rsp_valid}, 32'd1);

        // Slave never ready
        step(1'b1, 1'b0, 8'h09, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 100; i++) idle(1'b0);
`ifdef APB_MASTER_TIMEOUT_EN
        chk("to_idle", {31'd0, busy}, 32'd0);
        chk("to_err", {31'd0, rsp_err}, 32'd1);
        chk("to_rdata", {24'd0, rsp_rdata}, 32'h00);
`else
        chk("noto_sel", {31'd0, PSELx}, 32'd1);
        chk("noto_en", {31'd0, PENABLE}, 32'd1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hC3);
        chk("noto_finish", {24'd0, rsp_rdata}, 32'hC3);
`endif
        idle(1'b0);

        // Reset during ACCESS of a write
        step(1'b1, 1'b1, 8'h02, 8'h99, 1'b0, 1'b0, 8'h00);
        idle(1'b0);
        chk("rst_mid_in_access", {31'd0, PENABLE}, 32'd1);
        PRESET = 1'b1;
        #1;
        chk("rst_mid_sel", {31'd0, PSELx}, 32'd0);
        chk("rst_mid_en", {31'd0, PENABLE}, 32'd0);
        chk("rst_mid_pwrite", {31'd0, PWRITE}, 32'd0);
        chk("rst_mid_paddr", {24'd0, PADDR}, 32'd0);
        chk("rst_mid_pwdata", {24'd0, PWDATA}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        PREADY = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid_rsp_err", {31'd0, rsp_err}, 32'd0);
        PRESET = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 8'h0A, 8'h5C, 1'b1, 1'b0, 8'h00);
        chk("post_rst_accept", {31'd0, PSELx}, 32'd1);
        idle(1'b1);
        idle(1'b1);
        chk("post_rst_rsp", {31'd0, rsp_valid}, 32'd1);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
